// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared operation encoding and strobe priority decode for pc_sequencer
package pc_seq_pkg;
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_INC   = 3'd1,
    OP_REL   = 3'd2,
    OP_LOAD  = 3'd3,
    OP_CALL  = 3'd4,
    OP_RET   = 3'd5,
    OP_STALL = 3'd6
  } pc_op_t;
  function automatic pc_op_t pc_decode(input logic stall, ret, call, load, rel_en, pc_inc);
    return stall ? OP_STALL : ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD :
           rel_en ? OP_REL : pc_inc ? OP_INC : OP_HOLD;
  endfunction
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder-to-sequencer control strobes and PC/stack status
interface pc_sequencer_if #(parameter int PC_W = 8, parameter int REL_W = 8);
  logic             stall;
  logic [PC_W-1:0]  pc_in;
  logic             load;
  logic             pc_inc;
  logic             rel_en;
  logic [REL_W-1:0] rel_off;
  logic             call;
  logic             ret;
  logic [PC_W-1:0]  pout;
  logic             stack_empty;
  logic             stack_full;
  logic             stack_err;
  modport master (output stall, pc_in, load, pc_inc, rel_en, rel_off, call, ret,
                  input pout, stack_empty, stack_full, stack_err);
  modport slave (input stall, pc_in, load, pc_inc, rel_en, rel_off, call, ret,
                 output pout, stack_empty, stack_full, stack_err);
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// pc_ret_stack: return-address LIFO that ignores push when full and pop when empty
module pc_ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int SP_W  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    top,
  output logic            empty,
  output logic            full,
  output logic [SP_W-1:0] sp
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  logic [W-1:0]    r_mem [0:(1<<IW)-1];
  logic [SP_W-1:0] r_sp;
  logic            w_push;
  logic            w_pop;
  assign empty  = (r_sp == '0);
  assign full   = (r_sp == SP_FULL);
  assign sp     = r_sp;
  assign w_pop  = pop && !empty;
  assign w_push = push && !pop && !full;
  assign top    = r_mem[empty ? '0 : IW'(r_sp - 1'b1)];
  always_ff @(posedge clk) begin
    if (rst) r_sp <= '0;
    else if (w_pop) r_sp <= r_sp - 1'b1;
    else if (w_push) r_sp <= r_sp + 1'b1;
  end
  // contents are deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[IW'(r_sp)] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised PC with return stack, stall and reset vector.
// Relative branching is compiled in only when PC_SEQ_REL_BRANCH_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int DEPTH = 4,
  parameter int REL_W = 8,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  localparam int SP_W = $clog2(DEPTH + 1);
  pc_op_t          w_op;
  logic            w_rel_en;
  logic [PC_W-1:0] w_rel;
  logic [PC_W-1:0] w_inc;
  logic [PC_W-1:0] w_top;
  logic [PC_W-1:0] w_next;
  logic            w_empty;
  logic            w_full;
  logic [SP_W-1:0] w_sp;
  logic [PC_W-1:0] r_pc;
  logic            r_err;
`ifdef PC_SEQ_REL_BRANCH_EN
  assign w_rel_en = bus.rel_en;
  assign w_rel    = r_pc + PC_W'($signed(bus.rel_off));
`else
  logic w_unused;
  assign w_unused = ^{bus.rel_en, bus.rel_off};
  assign w_rel_en = 1'b0;
  assign w_rel    = r_pc;
`endif
  assign w_op  = pc_decode(bus.stall, bus.ret, bus.call, bus.load, w_rel_en, bus.pc_inc);
  assign w_inc = r_pc + 1'b1;
  pc_ret_stack #(.W(PC_W), .DEPTH(DEPTH), .SP_W(SP_W)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_op == OP_CALL),
    .pop   (w_op == OP_RET),
    .din   (w_inc),
    .top   (w_top),
    .empty (w_empty),
    .full  (w_full),
    .sp    (w_sp)
  );
  always_comb begin
    w_next = (w_op == OP_RET)  ? (w_empty ? r_pc : w_top) :
             (w_op == OP_CALL) ? (w_full ? r_pc : bus.pc_in) :
             (w_op == OP_LOAD) ? bus.pc_in :
             (w_op == OP_REL)  ? w_rel :
             (w_op == OP_INC)  ? w_inc : r_pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VEC;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_next;
      r_err <= r_err | ((w_op == OP_RET) && w_empty) | ((w_op == OP_CALL) && w_full);
    end
  end
  assign bus.pout        = r_pc;
  assign bus.stack_empty = w_empty;
  assign bus.stack_full  = w_full;
  assign bus.stack_err   = r_err;
endmodule
